data_mem_arbiter: RTL and testbench
===================================

// Module: data_mem_arbiter
// PURPOSE
//  Two-port arbiter/sequencer in front of the single-port DataMemory (clk, memWrite, memRead, address, writeData, readData).
//  Port 0 = CPU load/store unit, port 1 = debug/DMA loader. Round-robin grant, one access in flight.
//  Registers the winner's request, drives DataMemory strobes for exactly one cycle, then returns ack/rdata/err.
//  Rejects misaligned and out-of-range addresses without touching memory.
// PARAMETERS
//  ADDR_W     32    byte-address width of ports and memory
//  DATA_W     32    data width
//  MEM_BYTES  1024  implemented memory size in bytes; addr >= MEM_BYTES is out of range
// PORTS
//  clk        in   1       single clock, rising edge
//  rst_n      in   1       synchronous, active-low reset
//  pN_req     in   1       N=0,1: request; held with we/addr/wdata stable until pN_ack
//  pN_we      in   1       1 = store, 0 = load
//  pN_addr    in   ADDR_W  byte address, word-aligned
//  pN_wdata   in   DATA_W  store data
//  pN_ack     out  1       one-cycle completion pulse
//  pN_err     out  1       valid with pN_ack: 1 = misaligned or out of range, no access performed
//  pN_rdata   out  DATA_W  load data, valid with pN_ack when we=0 and err=0; holds until next ack to port N
//  mem_read   out  1       to DataMemory memRead
//  mem_write  out  1       to DataMemory memWrite
//  mem_addr   out  ADDR_W  to DataMemory address
//  mem_wdata  out  DATA_W  to DataMemory writeData
//  mem_rdata  in   DATA_W  from DataMemory readData; sampled at the rising edge that ends ISSUE
//  busy       out  1       1 in ISSUE and DONE
// BEHAVIOUR
//  All outputs are registered. On reset: state=IDLE, last_grant=1, all strobes/acks/errs=0, mem_addr/mem_wdata/pN_rdata=0.
//  FSM:
//   - IDLE: if any req, pick the winner, latch we/addr/wdata/err_flag and go to ISSUE; else stay in IDLE.
//   - ISSUE (1 cycle): if err_flag=0, assert mem_write (we=1) or mem_read (we=0) with latched addr/wdata; if err_flag=1, assert no strobe. Go to DONE.
//   - DONE (1 cycle): pulse pN_ack (and pN_err) for the winner; load result in pN_rdata. Set last_grant=winner.
//       Re-arbitrate in the same cycle, ignoring the winner's req (it is still high):
//       go to ISSUE if the other port requests, else go to IDLE.
//  Latency: req sampled in IDLE at edge T -> ISSUE in T+1 -> ack in T+2 (3 cycles).
//  Back-to-back alternating ports: one access every 2 cycles. Same port repeatedly: one access every 3 cycles.
//  Arbitration: only one req -> that port. Both -> the port != last_grant. First contention after reset goes to port 0.
//  err_flag = (addr[1:0] != 0) || (addr >= MEM_BYTES). Computed at latch time.
//  Write data reaches memory at the edge that ends ISSUE; read data is captured at that same edge.
//  Strobes are never both high, and never high outside ISSUE.
//  Protocol violation (req dropped before ack): the access still completes and ack still pulses. No abort.
//  Reset mid-operation: the next edge clears state and outputs; no ack is issued for the aborted access.
//   A write whose ISSUE cycle coincided with the reset edge is allowed to land in memory.
//  Addresses are not translated: mem_addr = latched pN_addr.
// STRUCTURE
//  Package dm_arb_pkg:
//   - state enum {IDLE, ISSUE, DONE}
//   - localparams PORT_CPU=0, PORT_DBG=1
//   - function addr_err(addr, MEM_BYTES)
//  Sub-module rr_pick2: inputs req[1:0], last, mask[1:0]; outputs gnt_valid, gnt_idx.
//   Purely combinational; instantiated once and shared by the IDLE and DONE decisions.
// TESTING
//  1. Port 0 only: store 0x0000_0004 <- 0xAABBCCDD. mem_write=1 for exactly 1 cycle; p0_ack 2 cycles after the req edge; err=0.
//  2. Port 1 load 0x4 after test 1 -> p1_rdata=0xAABBCCDD with p1_ack; mem_read=1 for 1 cycle; p0_ack stays 0.
//  3. Both req from reset: p0 store 0x8<-0x11223344 and p1 load 0x8.
//     Required order: p0 ack first, then p1 ISSUE in the cycle right after p0's DONE. p1_rdata=0x11223344.
//  4. p0 addr 0x6 (misaligned) and p1 addr 0x400 (MEM_BYTES=1024): both ack with err=1; mem_read/mem_write never assert.
//  5. Both ports hold req for 6 accesses: grants alternate 0,1,0,1,0,1; no port starves; strobes never overlap.
//  6. rst_n=0 during ISSUE of a p1 load: no p1_ack; next cycle busy=0, strobes=0. After release, p0 is granted first.

Source files
------------

// File: rtl/dm_arb_pkg.sv
// rtl/dm_arb_pkg.sv - shared types, port ids and address check for the DataMemory arbiter
// Purpose: FSM state encoding, port index constants and the address legality check
//          used by data_mem_arbiter when it latches a request.
// Ports:   none (package).
package dm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  // Word-aligned and inside the implemented memory; widened to 64 bits so any
  // ADDR_W up to 64 can share one helper.
  function automatic logic addr_err(input logic [63:0] addr, input logic [63:0] memBytes);
    return (addr[1:0] != 2'b00) || (addr >= memBytes);
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - two-requester round-robin pick, purely combinational
// Purpose: choose one of two requesters; on contention the one that was not
//          granted last wins. Masked requesters are ignored.
// Ports:   req[1:0]  raw requests
//          last      index of the most recent grant
//          mask[1:0] 1 = ignore this requester
//          gnt_valid some unmasked requester is active
//          gnt_idx   chosen requester (meaningful when gnt_valid)
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic [1:0] mask,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  logic [1:0] eligible;

  assign eligible  = req & ~mask;
  assign gnt_valid = |eligible;

  always_comb begin
    gnt_idx = 1'b0;
    if (eligible == 2'b11) begin
      gnt_idx = ~last;
    end else if (eligible[1]) begin
      gnt_idx = 1'b1;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - two-port round-robin sequencer in front of single-port DataMemory
// Purpose: grant one of two requesters, drive the memory strobe for exactly one
//          cycle (ISSUE), then return ack/err/rdata in the following cycle (DONE).
//          Misaligned or out-of-range addresses complete with err and never strobe.
// Ports:   clk, rst_n                        clock, synchronous active-low reset
//          pN_req/we/addr/wdata (N=0,1)      request held stable until pN_ack
//          pN_ack/err/rdata                  completion pulse, error flag, load data
//          mem_read/mem_write/mem_addr/mem_wdata  DataMemory controls
//          mem_rdata                         DataMemory read data
//          busy                              high in ISSUE and DONE
module data_mem_arbiter
  import dm_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic              p0_err,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic              p1_err,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  state_t state;
  logic   lastGrant;
  logic   winner;
  logic   latchWe;
  logic   latchErr;

  logic              gntValid;
  logic              gntIdx;
  logic              pickLast;
  logic [1:0]        pickMask;
  logic              selWe;
  logic [ADDR_W-1:0] selAddr;
  logic [DATA_W-1:0] selWdata;
  logic              selErr;
  logic              doLatch;

  // In DONE the winner's req is still high; mask it so only the other port
  // can be picked. In IDLE both are eligible and lastGrant breaks ties.
  always_comb begin
    pickLast = lastGrant;
    pickMask = 2'b00;
    if (state == DONE) begin
      pickLast = winner;
      pickMask = (winner == PORT_DBG) ? 2'b10 : 2'b01;
    end
  end

  rr_pick2 uPick (
    .req       ({p1_req, p0_req}),
    .last      (pickLast),
    .mask      (pickMask),
    .gnt_valid (gntValid),
    .gnt_idx   (gntIdx)
  );

  assign selWe    = (gntIdx == PORT_DBG) ? p1_we    : p0_we;
  assign selAddr  = (gntIdx == PORT_DBG) ? p1_addr  : p0_addr;
  assign selWdata = (gntIdx == PORT_DBG) ? p1_wdata : p0_wdata;
  assign selErr   = addr_err(64'(selAddr), 64'(MEM_BYTES));
  assign doLatch  = gntValid && ((state == IDLE) || (state == DONE));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      lastGrant <= PORT_DBG;
      winner    <= PORT_CPU;
      latchWe   <= 1'b0;
      latchErr  <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      p0_ack    <= 1'b0;
      p0_err    <= 1'b0;
      p0_rdata  <= '0;
      p1_ack    <= 1'b0;
      p1_err    <= 1'b0;
      p1_rdata  <= '0;
      busy      <= 1'b0;
    end else begin
      // Pulses default low; strobes only ever live for the single ISSUE cycle.
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      p0_ack    <= 1'b0;
      p0_err    <= 1'b0;
      p1_ack    <= 1'b0;
      p1_err    <= 1'b0;

      // Strobes are registered here so they are high exactly during ISSUE.
      if (doLatch) begin
        winner    <= gntIdx;
        latchWe   <= selWe;
        latchErr  <= selErr;
        mem_addr  <= selAddr;
        mem_wdata <= selWdata;
        mem_write <= selWe && !selErr;
        mem_read  <= !selWe && !selErr;
      end

      case (state)
        IDLE: begin
          if (gntValid) begin
            state <= ISSUE;
            busy  <= 1'b1;
          end
        end
        ISSUE: begin
          // This edge is when memory commits the write / presents read data.
          state <= DONE;
          if (winner == PORT_DBG) begin
            p1_ack <= 1'b1;
            p1_err <= latchErr;
            if (!latchWe && !latchErr) p1_rdata <= mem_rdata;
          end else begin
            p0_ack <= 1'b1;
            p0_err <= latchErr;
            if (!latchWe && !latchErr) p0_rdata <= mem_rdata;
          end
        end
        DONE: begin
          lastGrant <= winner;
          if (gntValid) begin
            state <= ISSUE;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - directed self-checking bench for data_mem_arbiter
module tb_data_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_ack, p0_err, p1_ack, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy;

  int nCmp;
  int nFail;
  int writeCnt;
  int readCnt;
  int overlapCnt;

  logic [31:0] memArr [0:255];

  data_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_BYTES(1024)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .p0_req    (p0_req),
    .p0_we     (p0_we),
    .p0_addr   (p0_addr),
    .p0_wdata  (p0_wdata),
    .p0_ack    (p0_ack),
    .p0_err    (p0_err),
    .p0_rdata  (p0_rdata),
    .p1_req    (p1_req),
    .p1_we     (p1_we),
    .p1_addr   (p1_addr),
    .p1_wdata  (p1_wdata),
    .p1_ack    (p1_ack),
    .p1_err    (p1_err),
    .p1_rdata  (p1_rdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DataMemory model: combinational read, write at rising edge.
  assign mem_rdata = memArr[mem_addr[9:2]];
  always @(posedge clk) begin
    if (mem_write) memArr[mem_addr[9:2]] <= mem_wdata;
  end

  always @(negedge clk) begin
    if (mem_write) writeCnt++;
    if (mem_read) readCnt++;
    if (mem_write && mem_read) overlapCnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
    p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
    tick();
    tick();
    nCmp++; if (busy !== 1'b0) begin nFail++; $display("FAIL rst_busy act=%b exp=0", busy); end
    nCmp++; if ({mem_read, mem_write} !== 2'b00) begin nFail++; $display("FAIL rst_strobes act=%b exp=00", {mem_read, mem_write}); end
    nCmp++; if ({p0_ack, p0_err, p1_ack, p1_err} !== 4'b0) begin nFail++; $display("FAIL rst_acks act=%b exp=0000", {p0_ack, p0_err, p1_ack, p1_err}); end
    nCmp++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin nFail++; $display("FAIL rst_memaddr act=%h/%h exp=0/0", mem_addr, mem_wdata); end
    nCmp++; if (p0_rdata !== 32'h0 || p1_rdata !== 32'h0) begin nFail++; $display("FAIL rst_rdata act=%h/%h exp=0/0", p0_rdata, p1_rdata); end
    rst_n = 1'b1;
    tick();
    nCmp++; if (busy !== 1'b0) begin nFail++; $display("FAIL rst_idle_busy act=%b exp=0", busy); end
  endtask

  task automatic test_p0_store();
    int w0;
    w0 = writeCnt;
    p0_req = 1; p0_we = 1; p0_addr = 32'h4; p0_wdata = 32'hAABBCCDD;
    tick();
    nCmp++; if (mem_write !== 1'b1 || mem_read !== 1'b0) begin nFail++; $display("FAIL st_issue_strobe act=w%b r%b exp=w1 r0", mem_write, mem_read); end
    nCmp++; if (mem_addr !== 32'h4 || mem_wdata !== 32'hAABBCCDD) begin nFail++; $display("FAIL st_issue_bus act=%h/%h exp=4/aabbccdd", mem_addr, mem_wdata); end
    nCmp++; if (busy !== 1'b1 || p0_ack !== 1'b0) begin nFail++; $display("FAIL st_issue_busy act=b%b a%b exp=b1 a0", busy, p0_ack); end
    tick();
    nCmp++; if (p0_ack !== 1'b1 || p0_err !== 1'b0) begin nFail++; $display("FAIL st_ack act=a%b e%b exp=a1 e0", p0_ack, p0_err); end
    nCmp++; if (mem_write !== 1'b0) begin nFail++; $display("FAIL st_done_wr act=%b exp=0", mem_write); end
    p0_req = 0;
    tick();
    nCmp++; if (p0_ack !== 1'b0 || busy !== 1'b0) begin nFail++; $display("FAIL st_idle act=a%b b%b exp=a0 b0", p0_ack, busy); end
    nCmp++; if (writeCnt - w0 !== 1) begin nFail++; $display("FAIL st_wr_cycles act=%0d exp=1", writeCnt - w0); end
  endtask

  task automatic test_p1_load();
    int r0;
    r0 = readCnt;
    p1_req = 1; p1_we = 0; p1_addr = 32'h4;
    tick();
    nCmp++; if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 32'h4) begin nFail++; $display("FAIL ld_issue act=r%b w%b a%h exp=r1 w0 a4", mem_read, mem_write, mem_addr); end
    tick();
    nCmp++; if (p1_ack !== 1'b1 || p1_err !== 1'b0) begin nFail++; $display("FAIL ld_ack act=a%b e%b exp=a1 e0", p1_ack, p1_err); end
    nCmp++; if (p1_rdata !== 32'hAABBCCDD) begin nFail++; $display("FAIL ld_rdata act=%h exp=aabbccdd", p1_rdata); end
    nCmp++; if (p0_ack !== 1'b0) begin nFail++; $display("FAIL ld_p0_quiet act=%b exp=0", p0_ack); end
    p1_req = 0;
    tick();
    nCmp++; if (p1_rdata !== 32'hAABBCCDD || p1_ack !== 1'b0) begin nFail++; $display("FAIL ld_hold act=%h a%b exp=aabbccdd a0", p1_rdata, p1_ack); end
    nCmp++; if (readCnt - r0 !== 1) begin nFail++; $display("FAIL ld_rd_cycles act=%0d exp=1", readCnt - r0); end
  endtask

  task automatic test_contention();
    rst_n = 0;
    tick();
    rst_n = 1;
    p0_req = 1; p0_we = 1; p0_addr = 32'h8; p0_wdata = 32'h11223344;
    p1_req = 1; p1_we = 0; p1_addr = 32'h8;
    tick();
    nCmp++; if (mem_write !== 1'b1 || mem_addr !== 32'h8) begin nFail++; $display("FAIL ct_p0_issue act=w%b a%h exp=w1 a8", mem_write, mem_addr); end
    tick();
    nCmp++; if (p0_ack !== 1'b1 || p1_ack !== 1'b0) begin nFail++; $display("FAIL ct_p0_first act=p0%b p1%b exp=p0 1 p1 0", p0_ack, p1_ack); end
    p0_req = 0;
    tick();
    nCmp++; if (mem_read !== 1'b1 || busy !== 1'b1 || p1_ack !== 1'b0) begin nFail++; $display("FAIL ct_p1_issue act=r%b b%b a%b exp=r1 b1 a0", mem_read, busy, p1_ack); end
    tick();
    nCmp++; if (p1_ack !== 1'b1 || p1_rdata !== 32'h11223344) begin nFail++; $display("FAIL ct_p1_done act=a%b d%h exp=a1 d11223344", p1_ack, p1_rdata); end
    p1_req = 0;
    tick();
  endtask

  task automatic test_errors();
    int w0, r0;
    logic got0, got1, e0, e1;
    w0 = writeCnt; r0 = readCnt;
    got0 = 0; got1 = 0; e0 = 0; e1 = 0;
    p0_req = 1; p0_we = 1; p0_addr = 32'h6; p0_wdata = 32'hDEADBEEF;
    p1_req = 1; p1_we = 0; p1_addr = 32'h400;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (p0_ack) begin got0 = 1; e0 = p0_err; p0_req = 0; end
      if (p1_ack) begin got1 = 1; e1 = p1_err; p1_req = 0; end
    end
    p0_req = 0; p1_req = 0;
    nCmp++; if ({got0, e0} !== 2'b11) begin nFail++; $display("FAIL er_p0 act=ack%b err%b exp=ack1 err1", got0, e0); end
    nCmp++; if ({got1, e1} !== 2'b11) begin nFail++; $display("FAIL er_p1 act=ack%b err%b exp=ack1 err1", got1, e1); end
    nCmp++; if ((writeCnt - w0) !== 0 || (readCnt - r0) !== 0) begin nFail++; $display("FAIL er_no_strobe act=w%0d r%0d exp=w0 r0", writeCnt - w0, readCnt - r0); end
    nCmp++; if (p1_rdata !== 32'h11223344) begin nFail++; $display("FAIL er_rdata_hold act=%h exp=11223344", p1_rdata); end
  endtask

  task automatic test_back_to_back();
    logic order [0:5];
    int nAck, p1Cnt, lastCyc, badGap;
    nAck = 0; p1Cnt = 0; lastCyc = -1; badGap = 0;
    for (int i = 0; i < 6; i++) order[i] = 1'bx;
    p0_req = 1; p0_we = 1; p0_addr = 32'h10; p0_wdata = 32'hC0DE0000;
    p1_req = 1; p1_we = 0; p1_addr = 32'h10;
    for (int c = 0; c < 40 && nAck < 6; c++) begin
      tick();
      if (p0_ack || p1_ack) begin
        if (lastCyc >= 0 && (c - lastCyc) != 2) badGap++;
        lastCyc = c;
      end
      if (p0_ack) begin
        order[nAck] = 1'b0;
        nAck++;
        p0_addr = p0_addr + 4;
        p0_wdata = p0_wdata + 1;
      end else if (p1_ack) begin
        order[nAck] = 1'b1;
        nCmp++; if (p1_rdata !== (32'hC0DE0000 + 32'(p1Cnt))) begin nFail++; $display("FAIL bb_rdata%0d act=%h exp=%h", p1Cnt, p1_rdata, 32'hC0DE0000 + 32'(p1Cnt)); end
        p1Cnt++;
        nAck++;
        p1_addr = p1_addr + 4;
      end
      if (nAck == 6) begin p0_req = 0; p1_req = 0; end
    end
    p0_req = 0; p1_req = 0;
    nCmp++; if (nAck !== 6) begin nFail++; $display("FAIL bb_count act=%0d exp=6", nAck); end
    for (int i = 0; i < 6; i++) begin
      nCmp++; if (order[i] !== 1'(i % 2)) begin nFail++; $display("FAIL bb_order%0d act=%b exp=%0d", i, order[i], i % 2); end
    end
    nCmp++; if (badGap !== 0) begin nFail++; $display("FAIL bb_spacing act=%0d bad gaps exp=0", badGap); end
    tick();
    tick();
    nCmp++; if (busy !== 1'b0) begin nFail++; $display("FAIL bb_idle act=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid();
    p1_req = 1; p1_we = 0; p1_addr = 32'h4;
    tick();
    nCmp++; if (mem_read !== 1'b1) begin nFail++; $display("FAIL rm_issue act=%b exp=1", mem_read); end
    rst_n = 0;
    p0_req = 1; p0_we = 0; p0_addr = 32'h8;
    tick();
    nCmp++; if (p1_ack !== 1'b0) begin nFail++; $display("FAIL rm_no_ack act=%b exp=0", p1_ack); end
    nCmp++; if (busy !== 1'b0 || {mem_read, mem_write} !== 2'b00) begin nFail++; $display("FAIL rm_cleared act=b%b s%b exp=b0 s00", busy, {mem_read, mem_write}); end
    rst_n = 1;
    tick();
    nCmp++; if (mem_read !== 1'b1 || mem_addr !== 32'h8) begin nFail++; $display("FAIL rm_p0_grant act=r%b a%h exp=r1 a8", mem_read, mem_addr); end
    tick();
    nCmp++; if (p0_ack !== 1'b1 || p1_ack !== 1'b0 || p0_rdata !== 32'h11223344) begin nFail++; $display("FAIL rm_p0_ack act=a0%b a1%b d%h exp=1 0 11223344", p0_ack, p1_ack, p0_rdata); end
    p0_req = 0; p1_req = 0;
    tick();
    tick();
  endtask

  initial begin
    nCmp = 0; nFail = 0;
    writeCnt = 0; readCnt = 0; overlapCnt = 0;
    test_reset();
    test_p0_store();
    test_p1_load();
    test_contention();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    nCmp++; if (overlapCnt !== 0) begin nFail++; $display("FAIL strobe_overlap act=%0d exp=0", overlapCnt); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
